daq_mode_sequencer: RTL and testbench

DAQ_MODE_SEQUENCER -- requirements
Module: daq_mode_sequencer

---
 rtl/daq_mode_sequencer.sv | 136 +++++++++++++
 tb/tb_daq_mode_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/daq_mode_sequencer.sv
// Arbitrates ownership of the DAQ datapath between the AutoDaq and SlaveDaq engines,
// draining the current owner and pulsing the ASIC reset plus a power settle window on every switch.
module daq_mode_sequencer #(
    parameter int unsigned RESET_PULSE_CYCLES = 8,
    parameter int unsigned SETTLE_CYCLES      = 200,
    parameter int unsigned DRAIN_TIMEOUT      = 65535
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       DaqSelect,
    input  logic       UsbAcqStart,
    input  logic       AutoDaq_Busy,
    input  logic       SlaveDaq_Busy,
    output logic       AutoAcq_Start,
    output logic       SlaveAcq_Start,
    output logic       ActiveDaq,
    output logic       Seq_RESET_B,
    output logic       PwrForceOn,
    output logic       SwitchBusy,
    output logic       DrainTimeout,
    output logic [2:0] seq_state
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_RESET  = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    // Loads are length-1: a state lasts load+1 cycles, leaving on the edge where the count is 0.
    localparam logic [15:0] RESET_LOAD  = 16'(RESET_PULSE_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DRAIN_LOAD  = 16'(DRAIN_TIMEOUT - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        active_nxt;
    logic        timeout_set;
    logic        busy_sel;
    logic        switch_req;

    assign busy_sel   = ActiveDaq ? SlaveDaq_Busy : AutoDaq_Busy;
    assign switch_req = (DaqSelect != ActiveDaq);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        active_nxt  = ActiveDaq;
        timeout_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (switch_req) begin
                    state_nxt  = ST_RESET;
                    active_nxt = DaqSelect;
                    cnt_nxt    = RESET_LOAD;
                end else if (UsbAcqStart) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = 16'd0;
                end
            end
            ST_RUN: begin
                if (!UsbAcqStart || switch_req) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!busy_sel || cnt == 16'd0) begin
                    timeout_set = busy_sel;
                    if (switch_req) begin
                        state_nxt  = ST_RESET;
                        active_nxt = DaqSelect;
                        cnt_nxt    = RESET_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = 16'd0;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            ST_RESET: begin
                if (cnt == 16'd0) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt == 16'd0) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register itself.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= 16'd0;
            ActiveDaq      <= 1'b0;
            AutoAcq_Start  <= 1'b0;
            SlaveAcq_Start <= 1'b0;
            Seq_RESET_B    <= 1'b1;
            PwrForceOn     <= 1'b0;
            SwitchBusy     <= 1'b0;
            DrainTimeout   <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            ActiveDaq      <= active_nxt;
            AutoAcq_Start  <= (state == ST_RUN) && (state_nxt == ST_RUN) && !ActiveDaq;
            SlaveAcq_Start <= (state == ST_RUN) && (state_nxt == ST_RUN) && ActiveDaq;
            Seq_RESET_B    <= (state_nxt != ST_RESET);
            PwrForceOn     <= (state_nxt == ST_SETTLE);
            SwitchBusy     <= (state_nxt != ST_IDLE) && (state_nxt != ST_RUN);
            if (timeout_set) begin
                DrainTimeout <= 1'b1;
            end
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_daq_mode_sequencer.sv
// Directed bench for daq_mode_sequencer: per-cycle expected output words are queued by the
// stimulus thread and compared by a negedge monitor keyed on the cycle number.
module tb_daq_mode_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_RESET  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    logic       clk;
    logic       reset;
    logic       sel;
    logic       usb;
    logic       abusy;
    logic       sbusy;
    logic       auto_start;
    logic       slave_start;
    logic       active;
    logic       rst_b;
    logic       pwr;
    logic       sw_busy;
    logic       tmo;
    logic [2:0] st;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [41:0] exp_q[$];

    daq_mode_sequencer #(
        .RESET_PULSE_CYCLES(8),
        .SETTLE_CYCLES(200),
        .DRAIN_TIMEOUT(16)
    ) dut (
        .Clk(clk),
        .reset(reset),
        .DaqSelect(sel),
        .UsbAcqStart(usb),
        .AutoDaq_Busy(abusy),
        .SlaveDaq_Busy(sbusy),
        .AutoAcq_Start(auto_start),
        .SlaveAcq_Start(slave_start),
        .ActiveDaq(active),
        .Seq_RESET_B(rst_b),
        .PwrForceOn(pwr),
        .SwitchBusy(sw_busy),
        .DrainTimeout(tmo),
        .seq_state(st)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // expected word: {state, active, auto, slave, rst_b, pwr, switch_busy, timeout}
    function automatic logic [9:0] ev(input logic [2:0] s, input logic a, input logic au,
                                      input logic sl, input logic rb, input logic pw,
                                      input logic sb, input logic to);
        return {s, a, au, sl, rb, pw, sb, to};
    endfunction

    function automatic logic [9:0] dut_word();
        return {st, active, auto_start, slave_start, rst_b, pwr, sw_busy, tmo};
    endfunction

    // driver tasks
    task automatic push(input logic [9:0] e);
        logic [31:0] c;
        c = cyc;
        exp_q.push_back({c, e});
    endtask

    task automatic tick(input logic [9:0] e);
        @(posedge clk);
        #1;
        push(e);
    endtask

    task automatic ticks(input int n, input logic [9:0] e);
        for (int i = 0; i < n; i++) tick(e);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [41:0] item;
        while (exp_q.size() > 0 && int'(exp_q[0][41:10]) <= cyc) begin
            item = exp_q.pop_front();
            checks++;
            if (int'(item[41:10]) != cyc) begin
                errors++;
                $display("FAIL stale_entry cyc=%0d entry_cyc=%0d", cyc, item[41:10]);
            end else if (dut_word() !== item[9:0]) begin
                errors++;
                $display("FAIL outputs cyc=%0d got=%b exp=%b (st,act,au,sl,rstb,pwr,sbusy,tmo)",
                         cyc, dut_word(), item[9:0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        sel   = 1'b0;
        usb   = 1'b0;
        abusy = 1'b0;
        sbusy = 1'b0;
        ticks(2, ev(S_IDLE, 0, 0, 0, 1, 0, 0, 0));
        reset = 1'b0;
        tick(ev(S_IDLE, 0, 0, 0, 1, 0, 0, 0));

        // start on Auto: Start appears two edges after UsbAcqStart rises
        usb = 1'b1;
        tick(ev(S_RUN, 0, 0, 0, 1, 0, 0, 0));
        ticks(3, ev(S_RUN, 0, 1, 0, 1, 0, 0, 0));

        // switch to Slave while Auto is busy: drain, 8-cycle reset pulse, 200-cycle settle
        abusy = 1'b1;
        tick(ev(S_RUN, 0, 1, 0, 1, 0, 0, 0));
        sel = 1'b1;
        tick(ev(S_DRAIN, 0, 0, 0, 1, 0, 1, 0));
        ticks(10, ev(S_DRAIN, 0, 0, 0, 1, 0, 1, 0));
        abusy = 1'b0;
        ticks(8, ev(S_RESET, 1, 0, 0, 0, 0, 1, 0));
        ticks(50, ev(S_SETTLE, 1, 0, 0, 1, 1, 1, 0));
        sel = 1'b0;
        ticks(10, ev(S_SETTLE, 1, 0, 0, 1, 1, 1, 0));
        sel = 1'b1;
        ticks(140, ev(S_SETTLE, 1, 0, 0, 1, 1, 1, 0));
        tick(ev(S_IDLE, 1, 0, 0, 1, 0, 0, 0));
        tick(ev(S_RUN, 1, 0, 0, 1, 0, 0, 0));
        ticks(2, ev(S_RUN, 1, 0, 1, 1, 0, 0, 0));

        // drain timeout with SlaveDaq_Busy stuck high: 16 DRAIN cycles, then sticky flag
        sbusy = 1'b1;
        tick(ev(S_RUN, 1, 0, 1, 1, 0, 0, 0));
        usb = 1'b0;
        tick(ev(S_DRAIN, 1, 0, 0, 1, 0, 1, 0));
        ticks(15, ev(S_DRAIN, 1, 0, 0, 1, 0, 1, 0));
        tick(ev(S_IDLE, 1, 0, 0, 1, 0, 0, 1));
        sbusy = 1'b0;
        ticks(3, ev(S_IDLE, 1, 0, 0, 1, 0, 0, 1));

        // switch and start in the same IDLE cycle: switch wins, no Start before settle ends
        sel = 1'b0;
        usb = 1'b1;
        ticks(8, ev(S_RESET, 0, 0, 0, 0, 0, 1, 1));
        ticks(200, ev(S_SETTLE, 0, 0, 0, 1, 1, 1, 1));
        tick(ev(S_IDLE, 0, 0, 0, 1, 0, 0, 1));
        tick(ev(S_RUN, 0, 0, 0, 1, 0, 0, 1));
        ticks(2, ev(S_RUN, 0, 1, 0, 1, 0, 0, 1));

        // stop with owner idle: one DRAIN cycle then IDLE
        usb = 1'b0;
        tick(ev(S_DRAIN, 0, 0, 0, 1, 0, 1, 1));
        ticks(2, ev(S_IDLE, 0, 0, 0, 1, 0, 0, 1));

        // reset asserted on the 4th RESET cycle aborts at once
        sel = 1'b1;
        ticks(3, ev(S_RESET, 1, 0, 0, 0, 0, 1, 1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        sel   = 1'b0;
        #1;
        push(ev(S_IDLE, 0, 0, 0, 1, 0, 0, 0));
        tick(ev(S_IDLE, 0, 0, 0, 1, 0, 0, 0));
        reset = 1'b0;
        ticks(3, ev(S_IDLE, 0, 0, 0, 1, 0, 0, 0));

        // final report
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
